vga_frame_reader: RTL and testbench

- Downstream display stage of the keystone pipeline. pixel_map writes corrected pixels into the 320x240, 12-bit vga_in frame buffer; this block reads them out.
- Generates 640x480@60 VGA timing and fetches frame-buffer pixels with 2x2 pixel replication.
- Compensates BRAM read latency so RGB, sync and blank leave aligned.
- Reports frame boundaries so upstream can swap buffers.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_frame_reader_if.sv | 16 +
 rtl/addr_map.sv | 12 +
 rtl/vga_timing.sv | 50 +++++
 rtl/vga_frame_reader.sv | 81 ++++++++
 tb/tb_vga_frame_reader.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer geometry and the
// sync/blank bundle carried down the latency-compensation delay line.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = 10'd800;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_ADDR_W = 17;
  localparam int PIX_W     = 12;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } video_ctl_t;

  // Control levels shown while no pixel is being displayed.
  function automatic video_ctl_t ctl_idle(input logic sync_active);
    video_ctl_t c;
    c.hsync = ~sync_active;
    c.vsync = ~sync_active;
    c.blank = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port between the display reader and the 320x240 buffer.
interface vga_frame_reader_if;
  import vga_pkg::*;

  // No valid/ready here: rd_addr is a free-running read request answered
  // READ_LATENCY cycles later on pixel_in; rd_buf only moves when frame_start is high.
  logic [FB_ADDR_W-1:0] rd_addr;
  logic                 rd_buf;
  logic                 frame_start;
  logic [PIX_W-1:0]     pixel_in;
  logic                 buf_sel_req;

  modport master (output rd_addr, rd_buf, frame_start, input pixel_in, buf_sel_req);
  modport slave  (input rd_addr, rd_buf, frame_start, output pixel_in, buf_sel_req);

endinterface

// File: rtl/addr_map.sv
// Maps a 320x240 frame-buffer coordinate to a linear address: y*320 + x.
module addr_map
  import vga_pkg::*;
(
  input  logic [8:0]           x,
  input  logic [8:0]           y,
  output logic [FB_ADDR_W-1:0] addr
);

  assign addr = {y, 8'd0} + {2'd0, y, 6'd0} + {8'd0, x};

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 horizontal/vertical counters with raw sync/blank and frame wrap.
module vga_timing
  import vga_pkg::*;
#(
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [8:0] fb_x,
  output logic [8:0] fb_y,
  output video_ctl_t ctl,
  output logic       active,
  output logic       wrap
);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_last;
  logic       v_last;

  assign h_last = (hc == H_TOTAL - 10'd1);
  assign v_last = (vc == V_TOTAL - 10'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last) begin
      hc <= '0;
      vc <= v_last ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  always_comb begin
    active    = (hc < H_ACTIVE) && (vc < V_ACTIVE);
    ctl.blank = ~active;
    ctl.hsync = ((hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC))
                ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    ctl.vsync = ((vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC))
                ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    wrap      = h_last && v_last;
  end

  // Each frame-buffer pixel covers a 2x2 block of screen pixels.
  assign fb_x = hc[9:1];
  assign fb_y = vc[9:1];

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the frame buffer with 2x2 replication, aligning RGB with sync/blank
// across the buffer read latency, and latches the displayed buffer per frame.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter bit SYNC_ACTIVE  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  vga_frame_reader_if.master        fb,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      blank,
  output logic [3:0]                vga_r,
  output logic [3:0]                vga_g,
  output logic [3:0]                vga_b
);

  logic [8:0]           fb_x;
  logic [8:0]           fb_y;
  video_ctl_t           ctl_raw;
  logic                 active;
  logic                 wrap;
  logic [FB_ADDR_W-1:0] map_addr;

  video_ctl_t           ctl_dl [READ_LATENCY+1];
  video_ctl_t           ctl_out;
  logic [PIX_W-1:0]     rgb;

  vga_timing #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_timing (
    .clk    (clk),
    .reset  (reset),
    .fb_x   (fb_x),
    .fb_y   (fb_y),
    .ctl    (ctl_raw),
    .active (active),
    .wrap   (wrap)
  );

  addr_map u_addr_map (
    .x    (fb_x),
    .y    (fb_y),
    .addr (map_addr)
  );

  // Address stage and per-frame buffer latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb.rd_addr     <= '0;
      fb.rd_buf      <= 1'b0;
      fb.frame_start <= 1'b0;
    end else begin
      fb.rd_addr     <= active ? map_addr : '0;
      fb.frame_start <= wrap;
      if (wrap) fb.rd_buf <= fb.buf_sel_req;
    end
  end

  // ctl_dl[READ_LATENCY] lines up with pixel_in; one more register pairs it with rgb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= READ_LATENCY; i++) ctl_dl[i] <= ctl_idle(SYNC_ACTIVE);
      ctl_out <= ctl_idle(SYNC_ACTIVE);
      rgb     <= '0;
    end else begin
      ctl_dl[0] <= ctl_raw;
      for (int i = 1; i <= READ_LATENCY; i++) ctl_dl[i] <= ctl_dl[i-1];
      ctl_out <= ctl_dl[READ_LATENCY];
      rgb     <= ctl_dl[READ_LATENCY].blank ? '0 : fb.pixel_in;
    end
  end

  assign hsync = ctl_out.hsync;
  assign vsync = ctl_out.vsync;
  assign blank = ctl_out.blank;
  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: BRAM model, per-cycle reference model, vector table.
module tb_vga_frame_reader;

  localparam int L     = 2;
  localparam int FRAME = 800 * 525;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       hsync, vsync, blank;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_frame_reader_if fb();

  vga_frame_reader #(.READ_LATENCY(L), .SYNC_ACTIVE(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (fb),
    .hsync (hsync),
    .vsync (vsync),
    .blank (blank),
    .vga_r (vga_r),
    .vga_g (vga_g),
    .vga_b (vga_b)
  );

  // ---------------- frame-buffer model ----------------
  function automatic logic [11:0] pix(input logic [16:0] a);
    return a[11:0] ^ {a[16:12], 7'd0};
  endfunction

  logic [16:0] pipe [L] = '{default: 17'd0};
  always @(posedge clk) begin
    pipe[0] <= fb.rd_addr;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign fb.pixel_in = pix(pipe[L-1]);

  // ---------------- cycle count and buffer model ----------------
  int   n = 0;
  logic exp_rd_buf = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n          <= 0;
      exp_rd_buf <= 1'b0;
    end else begin
      if (n % FRAME == FRAME - 1) exp_rd_buf <= fb.buf_sel_req;
      n <= n + 1;
    end
  end

  typedef struct {
    logic [16:0] addr;
    logic        hs, vs, bl, fs;
    logic [11:0] rgb;
  } exp_t;

  // Cycle n shows counters at screen position n; rd_addr is for n-1, video for n-L-2.
  function automatic exp_t model(input int cyc);
    exp_t e;
    int m, h, v;
    e.addr = '0; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.rgb = '0;
    m = cyc - 1;
    if (m >= 0) begin
      h = m % 800; v = (m / 800) % 525;
      if (h < 640 && v < 480) e.addr = 17'((v / 2) * 320 + h / 2);
    end
    m = cyc - (L + 2);
    if (m >= 0) begin
      h = m % 800; v = (m / 800) % 525;
      e.hs = !(h >= 656 && h < 752);
      e.vs = !(v >= 490 && v < 492);
      e.bl = !(h < 640 && v < 480);
      if (!e.bl) e.rgb = pix(17'((v / 2) * 320 + h / 2));
    end
    e.fs = (cyc > 0) && (cyc % FRAME == 0);
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  int    tests = 0;
  int    fails = 0;
  int    mism = 0;
  int    vlow = 0;
  int    fs_cnt = 0;
  string first_diff = "";
  exp_t  me;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  always @(negedge clk) begin
    me = model(n);
    if (fb.rd_addr !== me.addr || hsync !== me.hs || vsync !== me.vs || blank !== me.bl ||
        {vga_r, vga_g, vga_b} !== me.rgb || fb.frame_start !== me.fs || fb.rd_buf !== exp_rd_buf) begin
      mism++;
      if (mism == 1)
        first_diff = $sformatf("cycle %0d reset %0b: addr %0d/%0d hs %0b/%0b vs %0b/%0b bl %0b/%0b rgb %h/%h fs %0b/%0b buf %0b/%0b",
          n, reset, fb.rd_addr, me.addr, hsync, me.hs, vsync, me.vs, blank, me.bl,
          {vga_r, vga_g, vga_b}, me.rgb, fb.frame_start, me.fs, fb.rd_buf, exp_rd_buf);
    end
    if (!reset && n >= L + 2 && n < FRAME + L + 2 && !vsync) vlow++;
    if (fb.frame_start) fs_cnt++;
  end

  // ---------------- driver ----------------
  task automatic wait_n(input int target);
    int budget = 0;
    while (n < target && budget < 600000) begin
      @(negedge clk);
      budget++;
    end
    if (n != target) begin
      tests++;
      fails++;
      $display("FAIL wait_n: at cycle %0d, wanted %0d", n, target);
    end
  endtask

  initial begin
    fb.buf_sel_req = 1'b0;
    forever begin
      @(negedge clk);
      if ((n >= FRAME - 1000 && n < FRAME) || (n >= 200000 && n < 210000))
        fb.buf_sel_req = 1'b1;
      else if ($urandom_range(0, 499) == 0)
        fb.buf_sel_req = ~fb.buf_sel_req;
    end
  end

  typedef struct {
    int          hc, vc;
    logic [16:0] addr;
    logic        bl, hs, vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs [13];

  task automatic run_vec(input int i);
    int pos;
    pos = vecs[i].vc * 800 + vecs[i].hc;
    wait_n(pos + 1);
    check($sformatf("addr(%0d,%0d)", vecs[i].hc, vecs[i].vc), fb.rd_addr, vecs[i].addr);
    wait_n(pos + L + 2);
    check($sformatf("blank(%0d,%0d)", vecs[i].hc, vecs[i].vc), blank, vecs[i].bl);
    check($sformatf("hsync(%0d,%0d)", vecs[i].hc, vecs[i].vc), hsync, vecs[i].hs);
    check($sformatf("vsync(%0d,%0d)", vecs[i].hc, vecs[i].vc), vsync, vecs[i].vs);
    check($sformatf("rgb(%0d,%0d)", vecs[i].hc, vecs[i].vc), {vga_r, vga_g, vga_b}, vecs[i].rgb);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_addr"}, fb.rd_addr, 0);
    check({tag, "_rd_buf"}, fb.rd_buf, 0);
    check({tag, "_frame_start"}, fb.frame_start, 0);
    check({tag, "_blank"}, blank, 1);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
  endtask

  initial begin
    int c;
    //           hc   vc   addr    bl    hs    vs    rgb
    vecs[0]  = '{10,  0,   5,      1'b0, 1'b1, 1'b1, 12'h005};
    vecs[1]  = '{700, 0,   0,      1'b1, 1'b0, 1'b1, 12'h000};
    vecs[2]  = '{3,   5,   641,    1'b0, 1'b1, 1'b1, 12'h281};
    vecs[3]  = '{640, 5,   0,      1'b1, 1'b1, 1'b1, 12'h000};
    vecs[4]  = '{655, 10,  0,      1'b1, 1'b1, 1'b1, 12'h000};
    vecs[5]  = '{656, 11,  0,      1'b1, 1'b0, 1'b1, 12'h000};
    vecs[6]  = '{751, 12,  0,      1'b1, 1'b0, 1'b1, 12'h000};
    vecs[7]  = '{752, 13,  0,      1'b1, 1'b1, 1'b1, 12'h000};
    vecs[8]  = '{639, 479, 76799,  1'b0, 1'b1, 1'b1, 12'h2FF};
    vecs[9]  = '{0,   480, 0,      1'b1, 1'b1, 1'b1, 12'h000};
    vecs[10] = '{799, 489, 0,      1'b1, 1'b1, 1'b1, 12'h000};
    vecs[11] = '{100, 491, 0,      1'b1, 1'b1, 1'b0, 12'h000};
    vecs[12] = '{100, 492, 0,      1'b1, 1'b1, 1'b1, 12'h000};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Asynchronous reset mid-line at (300,100).
    wait_n(100 * 800 + 300);
    #2 reset = 1'b1;
    #1 check_idle("async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    c = 0;
    while (hsync && c < 2000) begin @(negedge clk); c++; end
    check("hsync_first_fall_cycle", n, 656 + L + 2);
    c = 0;
    while (!hsync && c < 200) begin @(negedge clk); c++; end
    check("hsync_low_length", c, 96);

    for (int i = 8; i < 13; i++) run_vec(i);

    wait_n(FRAME - 1);
    check("rd_buf_before_wrap", fb.rd_buf, 0);
    check("frame_start_before_wrap", fb.frame_start, 0);
    wait_n(FRAME);
    check("rd_buf_at_wrap", fb.rd_buf, 1);
    check("frame_start_at_wrap", fb.frame_start, 1);
    wait_n(FRAME + 1);
    check("frame_start_after_wrap", fb.frame_start, 0);
    check("rd_buf_after_wrap", fb.rd_buf, 1);

    wait_n(FRAME + 2000);
    if (mism != 0) $display("first cycle diff (got/expected): %s", first_diff);
    check("cycle_model_diffs", mism, 0);
    check("vsync_low_cycles", vlow, 1600);
    check("frame_start_pulses", fs_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
